datamem_responder: RTL and testbench

Responder side of the pipelined CPU's data-memory port: accepts one load or store request at a time over a valid/ready handshake and holds it for a fixed `LATENCY` cycles. It then commits the store or returns the load data with a one-cycle response pulse. It replaces the single-cycle data memory behind the MEM stage. `req_ready` drives the pipeline stall logic.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_align_check.sv | 65 ++++++
 rtl/datamem_responder.sv | 147 ++++++++++++++
 tb/tb_datamem_responder.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared types and constants for the data-memory responder and
//             its helpers. Contains the transfer-size encodings and the
//             responder FSM state type.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

    // Transfer sizes, expressed as a byte count.
    localparam logic [3:0] XFER_B = 4'd1;
    localparam logic [3:0] XFER_H = 4'd2;
    localparam logic [3:0] XFER_W = 4'd4;
    localparam logic [3:0] XFER_D = 4'd8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } dmem_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_align_check.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_align_check
//  Purpose  : Combinational legality check for one data-memory access.
//             Flags an illegal size, a misaligned address, or an access that
//             runs past the end of the array. Also produces the byte-lane
//             enable mask, relative to the start address.
//  Ports    : addr     in  64  byte address
//             size     in   4  transfer size in bytes
//             err      out  1  access is illegal
//             byte_en  out  8  lane i set when byte addr+i is part of the access
//  Revision : 1.0  initial release
// ============================================================================
module dmem_align_check
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024
) (
    input  logic [63:0] addr,
    input  logic [3:0]  size,
    output logic        err,
    output logic [7:0]  byte_en
);

    localparam logic [64:0] c_DEPTH = 65'(DEPTH_BYTES);

    logic        w_bad_size;
    logic        w_misalign;
    logic        w_oob;
    logic [64:0] w_end;

    always_comb begin
        w_bad_size = 1'b0;
        w_misalign = 1'b0;
        byte_en    = 8'h00;
        case (size)
            XFER_B: begin
                byte_en    = 8'h01;
            end
            XFER_H: begin
                byte_en    = 8'h03;
                w_misalign = addr[0];
            end
            XFER_W: begin
                byte_en    = 8'h0F;
                w_misalign = |addr[1:0];
            end
            XFER_D: begin
                byte_en    = 8'hFF;
                w_misalign = |addr[2:0];
            end
            default: begin
                w_bad_size = 1'b1;
            end
        endcase

        // One extra bit so an address near 2^64 cannot wrap past the check.
        w_end = {1'b0, addr} + 65'(size);
        w_oob = (w_end > c_DEPTH);

        err = w_bad_size | w_misalign | w_oob;
    end

endmodule
`default_nettype wire

// File: rtl/datamem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : datamem_responder
//  Purpose  : Fixed-latency data-memory responder for the MEM stage. Accepts
//             one load/store at a time over valid/ready, holds it LATENCY
//             cycles, then commits the store or returns load data with a
//             one-cycle response pulse. Little-endian byte array.
//  Ports    : clk, rst                    clock, synchronous active-high reset
//             req_valid/req_ready         request handshake
//             req_write, req_addr,
//             req_wdata, req_size         request fields (sampled on accept)
//             rsp_valid                   one-cycle response pulse
//             rsp_rdata                   zero-extended load data, else 0
//             rsp_err                     request rejected (with rsp_valid)
//  Revision : 1.0  initial release
// ============================================================================
module datamem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_size,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int c_ADDR_W = $clog2(DEPTH_BYTES);
    localparam int c_CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(LATENCY - 1);

    dmem_state_t        r_state;
    dmem_state_t        w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_accept;
    logic               w_fire;

    logic               r_write;
    logic [63:0]        r_addr;
    logic [63:0]        r_wdata;
    logic [3:0]         r_size;

    logic               w_err;
    logic [7:0]         w_byte_en;
    logic [63:0]        w_rdata;

    logic [7:0]         r_mem [DEPTH_BYTES];

    // The check runs on the latched request, so the requester may change
    // its inputs freely after the acceptance edge.
    dmem_align_check #(
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_align_check (
        .addr    (r_addr),
        .size    (r_size),
        .err     (w_err),
        .byte_en (w_byte_en)
    );

    // Last WAIT cycle: the access happens on this edge.
    assign w_fire = (r_state == WAIT) && (r_cnt == '0);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        req_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = WAIT;
                    w_cnt_next   = c_CNT_INIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            rsp_valid <= w_fire;
            rsp_err   <= w_fire & w_err;
            rsp_rdata <= (w_fire && !w_err && !r_write) ? w_rdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_size  <= req_size;
        end
    end

    // Lane i maps to byte addr+i; only enabled lanes are read, the rest
    // stay zero, which gives the zero extension for narrow loads.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < 8; i++) begin
            if (w_byte_en[i]) begin
                w_rdata[8*i +: 8] = r_mem[r_addr[c_ADDR_W-1:0] + c_ADDR_W'(i)];
            end
        end
    end

    // Byte array has no reset; reset during WAIT suppresses the commit.
    always_ff @(posedge clk) begin
        if (!rst && w_fire && r_write && !w_err) begin
            for (int i = 0; i < 8; i++) begin
                if (w_byte_en[i]) begin
                    r_mem[r_addr[c_ADDR_W-1:0] + c_ADDR_W'(i)] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_datamem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_datamem_responder
//  Purpose  : Directed self-checking bench for datamem_responder. One DUT
//             with LATENCY=3 and one with LATENCY=1 share clock and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_datamem_responder;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;

    logic        req_valid,  req_write;
    logic [63:0] req_addr,   req_wdata;
    logic [3:0]  req_size;
    logic        req_ready,  rsp_valid, rsp_err;
    logic [63:0] rsp_rdata;

    logic        req_valid1, req_write1;
    logic [63:0] req_addr1,  req_wdata1;
    logic [3:0]  req_size1;
    logic        req_ready1, rsp_valid1, rsp_err1;
    logic [63:0] rsp_rdata1;

    int checks;
    int errors;

    datamem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(3)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    datamem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) u_dut_l1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid1),
        .req_write (req_write1),
        .req_addr  (req_addr1),
        .req_wdata (req_wdata1),
        .req_size  (req_size1),
        .req_ready (req_ready1),
        .rsp_valid (rsp_valid1),
        .rsp_rdata (rsp_rdata1),
        .rsp_err   (rsp_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request to the selected DUT and wait (bounded) for its
    // response. lat counts edges from acceptance to the response pulse;
    // -1 means no response arrived.
    task automatic do_req(input bit sel, input bit w, input logic [63:0] a,
                          input logic [63:0] wd, input logic [3:0] sz,
                          output logic [63:0] rd, output bit er, output int lat);
        int n;
        n   = 0;
        rd  = '0;
        er  = 1'b0;
        lat = -1;
        while (!(sel ? req_ready1 : req_ready) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (sel) begin
            req_valid1 = 1'b1; req_write1 = w; req_addr1 = a; req_wdata1 = wd; req_size1 = sz;
        end else begin
            req_valid  = 1'b1; req_write  = w; req_addr  = a; req_wdata  = wd; req_size  = sz;
        end
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_valid1 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (sel ? rsp_valid1 : rsp_valid) begin
                lat = c;
                rd  = sel ? rsp_rdata1 : rsp_rdata;
                er  = sel ? rsp_err1   : rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b err=%b rdata=%h expected 1 0 0 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
                errors++;
                $display("FAIL idle_cycle%0d: ready=%b valid=%b err=%b rdata=%h expected 1 0 0 0",
                         c, req_ready, rsp_valid, rsp_err, rsp_rdata);
            end
        end
    endtask

    task automatic test_store_load();
        logic [63:0] rd;
        bit          er;
        int          lat;
        do_req(1'b0, 1'b1, 64'd16, 64'h0123_4567_89AB_CDEF, 4'd8, rd, er, lat);
        checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== 64'h0) begin
            errors++;
            $display("FAIL store8: lat=%0d err=%b rdata=%h expected 3 0 0", lat, er, rd);
        end
        do_req(1'b0, 1'b0, 64'd16, 64'h0, 4'd8, rd, er, lat);
        checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== 64'h0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL load8: lat=%0d err=%b rdata=%h expected 3 0 0123456789abcdef", lat, er, rd);
        end
    endtask

    task automatic test_partial();
        logic [63:0] rd;
        bit          er;
        int          lat;
        // Bytes 16..23 hold EF CD AB 89 67 45 23 01.
        do_req(1'b0, 1'b0, 64'd16, 64'h0, 4'd1, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 64'hEF) begin
            errors++;
            $display("FAIL load1_16: err=%b rdata=%h expected 0 ef", er, rd);
        end
        // Little-endian: byte 18 (AB) is the low byte, byte 19 (89) the high.
        do_req(1'b0, 1'b0, 64'd18, 64'h0, 4'd2, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 64'h89AB) begin
            errors++;
            $display("FAIL load2_18: err=%b rdata=%h expected 0 89ab", er, rd);
        end
        do_req(1'b0, 1'b1, 64'd20, 64'hFFFF_FFFF_DEAD_BEEF, 4'd4, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 64'h0) begin
            errors++;
            $display("FAIL store4_20: err=%b rdata=%h expected 0 0", er, rd);
        end
        do_req(1'b0, 1'b0, 64'd16, 64'h0, 4'd8, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 64'hDEAD_BEEF_89AB_CDEF) begin
            errors++;
            $display("FAIL load8_after_store4: err=%b rdata=%h expected 0 deadbeef89abcdef", er, rd);
        end
        do_req(1'b0, 1'b0, 64'd22, 64'h0, 4'd2, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 64'hDEAD) begin
            errors++;
            $display("FAIL load2_22: err=%b rdata=%h expected 0 dead", er, rd);
        end
    endtask

    task automatic test_errors();
        logic [63:0] rd;
        bit          er;
        int          lat;
        do_req(1'b0, 1'b1, 64'd0, 64'h1122_3344_5566_7788, 4'd8, rd, er, lat);
        checks++;
        if (er !== 1'b0) begin
            errors++;
            $display("FAIL store8_0: err=%b expected 0", er);
        end
        do_req(1'b0, 1'b0, 64'd2, 64'h0, 4'd4, rd, er, lat);
        checks++;
        if (lat !== 3 || er !== 1'b1 || rd !== 64'h0) begin
            errors++;
            $display("FAIL misalign_load4: lat=%0d err=%b rdata=%h expected 3 1 0", lat, er, rd);
        end
        do_req(1'b0, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd3, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 64'h0) begin
            errors++;
            $display("FAIL size3_store: err=%b rdata=%h expected 1 0", er, rd);
        end
        do_req(1'b0, 1'b1, 64'd8, 64'hFFFF_FFFF_FFFF_FFFF, 4'd4, rd, er, lat);
        checks++;
        if (er !== 1'b0) begin
            errors++;
            $display("FAIL store4_8: err=%b expected 0", er);
        end
        do_req(1'b0, 1'b1, 64'd6, 64'hAAAA, 4'd4, rd, er, lat);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL misalign_store4: err=%b expected 1", er);
        end
        do_req(1'b0, 1'b0, 64'd0, 64'h0, 4'd8, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 64'h1122_3344_5566_7788) begin
            errors++;
            $display("FAIL mem_after_errors: err=%b rdata=%h expected 0 1122334455667788", er, rd);
        end
        do_req(1'b0, 1'b0, 64'(DEPTH - 4), 64'h0, 4'd8, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 64'h0) begin
            errors++;
            $display("FAIL oob_load8: err=%b rdata=%h expected 1 0", er, rd);
        end
        // Last legal doubleword: addr + size == DEPTH.
        do_req(1'b0, 1'b1, 64'(DEPTH - 8), 64'hCAFE_F00D_1234_5678, 4'd8, rd, er, lat);
        checks++;
        if (er !== 1'b0) begin
            errors++;
            $display("FAIL edge_store8: err=%b expected 0", er);
        end
        do_req(1'b0, 1'b0, 64'(DEPTH - 8), 64'h0, 4'd8, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 64'hCAFE_F00D_1234_5678) begin
            errors++;
            $display("FAIL edge_load8: err=%b rdata=%h expected 0 cafef00d12345678", er, rd);
        end
        do_req(1'b0, 1'b0, 64'h1_0000_0000, 64'h0, 4'd1, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 64'h0) begin
            errors++;
            $display("FAIL high_addr_load1: err=%b rdata=%h expected 1 0", er, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] pulses;
        logic [16:0] exp_pulses;
        int          npulse;
        pulses     = '0;
        exp_pulses = 17'h0;
        exp_pulses[4]  = 1'b1;
        exp_pulses[8]  = 1'b1;
        exp_pulses[12] = 1'b1;
        npulse = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 4'd8;
        req_wdata = 64'h0;
        for (int e = 1; e <= 16; e++) begin
            req_addr = 64'(8 * e);
            @(posedge clk); #1;
            if (rsp_valid) begin
                pulses[e] = 1'b1;
                npulse++;
            end
            if (e == 2) begin
                checks++;
                if (req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_low_in_wait: ready=%b expected 0", req_ready);
                end
            end
            if (e == 4) begin
                checks++;
                if (req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_with_rsp: ready=%b expected 1", req_ready);
                end
            end
            if (e == 12) req_valid = 1'b0;
        end
        checks++;
        if (npulse !== 3) begin
            errors++;
            $display("FAIL pulse_count: got %0d expected 3", npulse);
        end
        checks++;
        if (pulses !== exp_pulses) begin
            errors++;
            $display("FAIL pulse_spacing: got %h expected %h", pulses, exp_pulses);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd;
        bit          er;
        int          lat;
        int          npulse;
        npulse = 0;
        do_req(1'b0, 1'b1, 64'd8, 64'h0102_0304_0506_0708, 4'd8, rd, er, lat);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'd8; req_wdata = 64'hFF; req_size = 4'd8;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        if (rsp_valid) npulse++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_state: ready=%b valid=%b expected 1 0", req_ready, rsp_valid);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) npulse++;
        end
        checks++;
        if (npulse !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_rsp: got %0d pulses expected 0", npulse);
        end
        do_req(1'b0, 1'b0, 64'd8, 64'h0, 4'd8, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 64'h0102_0304_0506_0708) begin
            errors++;
            $display("FAIL reset_mid_mem: err=%b rdata=%h expected 0 0102030405060708", er, rd);
        end
    endtask

    task automatic test_latency1();
        logic [63:0] rd;
        bit          er;
        int          lat;
        do_req(1'b1, 1'b1, 64'd32, 64'h5A5A_0000_1111_2222, 4'd8, rd, er, lat);
        checks++;
        if (lat !== 1 || er !== 1'b0 || rd !== 64'h0) begin
            errors++;
            $display("FAIL l1_store: lat=%0d err=%b rdata=%h expected 1 0 0", lat, er, rd);
        end
        checks++;
        if (req_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL l1_ready_with_rsp: ready=%b expected 1", req_ready1);
        end
        do_req(1'b1, 1'b0, 64'd34, 64'h0, 4'd2, rd, er, lat);
        checks++;
        if (lat !== 1 || er !== 1'b0 || rd !== 64'h1111) begin
            errors++;
            $display("FAIL l1_load2: lat=%0d err=%b rdata=%h expected 1 0 1111", lat, er, rd);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid1 !== 1'b0 || rsp_rdata1 !== 64'h0) begin
            errors++;
            $display("FAIL l1_pulse_width: valid=%b rdata=%h expected 0 0", rsp_valid1, rsp_rdata1);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        req_valid  = 1'b0; req_write  = 1'b0; req_addr  = '0; req_wdata  = '0; req_size  = '0;
        req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_size1 = '0;

        test_reset();
        test_store_load();
        test_partial();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_latency1();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
